bcp_scan_controller: RTL

- Sequences one Boolean-constraint-propagation pass over clause memory.
- For each clause it fetches the clause word and drives the external partial_sat_evaluator / unit_clause_evaluator pair from the current assignment vectors.
- Forwards each implication over a valid/ready stream and stops at the first conflicting clause.
- Sits between the clause RAM, the assignment register file and the implication queue.

---
 rtl/bcp_scan_controller.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/bcp_scan_controller.sv
// rtl/bcp_scan_controller.sv - one BCP pass over clause memory driving external evaluators
// Fetches each clause, evaluates it, forwards implications and stops at the first conflict.
module bcp_scan_controller #(
    parameter int VAR_PER_CLAUSE   = 5,
    parameter int VARIABLE_BITS    = 7,
    parameter int NUM_VARIABLE     = 128,
    parameter int CLAUSE_ADDR_BITS = 10,
    parameter int CLAUSE_W         = VAR_PER_CLAUSE*VARIABLE_BITS + 2*VAR_PER_CLAUSE
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic [CLAUSE_ADDR_BITS-1:0]             num_clauses,
    input  logic [NUM_VARIABLE-1:0]                 assigned,
    input  logic [NUM_VARIABLE-1:0]                 value,
    output logic                                    clause_rd_en,
    output logic [CLAUSE_ADDR_BITS-1:0]             clause_rd_addr,
    input  logic [CLAUSE_W-1:0]                     clause_rd_data,
    output logic [VAR_PER_CLAUSE-1:0]               ev_unassign,
    output logic [VAR_PER_CLAUSE-1:0]               ev_mask,
    output logic [VAR_PER_CLAUSE-1:0]               ev_val,
    output logic [VAR_PER_CLAUSE-1:0]               ev_pole,
    output logic [VAR_PER_CLAUSE*VARIABLE_BITS-1:0] ev_variable,
    input  logic                                    ev_partial_sat,
    input  logic                                    ev_is_unit,
    input  logic                                    ev_new_val,
    input  logic [VARIABLE_BITS-1:0]                ev_implied_var,
    output logic                                    imp_valid,
    input  logic                                    imp_ready,
    output logic [VARIABLE_BITS-1:0]                imp_var,
    output logic                                    imp_val,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    conflict,
    output logic [CLAUSE_ADDR_BITS-1:0]             conflict_clause,
    output logic [CLAUSE_ADDR_BITS:0]               imp_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_EVAL, S_EMIT, S_DONE
    } state_t;

    state_t                      state_q;
    logic [CLAUSE_ADDR_BITS-1:0] num_q;
    logic [CLAUSE_ADDR_BITS-1:0] idx_q;
    logic [CLAUSE_W-1:0]         clause_q;
    logic                        rd_en_q;
    logic [CLAUSE_ADDR_BITS-1:0] rd_addr_q;
    logic                        imp_valid_q;
    logic [VARIABLE_BITS-1:0]    imp_var_q;
    logic                        imp_val_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        conflict_q;
    logic [CLAUSE_ADDR_BITS-1:0] conflict_clause_q;
    logic [CLAUSE_ADDR_BITS:0]   imp_count_q;

    logic [VARIABLE_BITS-1:0]    lit_var;
    logic                        any_unassigned;
    logic                        eval_unit;
    logic                        eval_conflict;
    logic                        do_advance;
    logic [CLAUSE_ADDR_BITS:0]   idx_inc;
    logic                        last_clause;

    assign ev_pole     = clause_q[VAR_PER_CLAUSE-1:0];
    assign ev_mask     = clause_q[2*VAR_PER_CLAUSE-1:VAR_PER_CLAUSE];
    assign ev_variable = clause_q[CLAUSE_W-1:2*VAR_PER_CLAUSE];

    always_comb begin
        ev_unassign = '0;
        ev_val      = '0;
        lit_var     = '0;
        for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
            lit_var        = clause_q[2*VAR_PER_CLAUSE + VARIABLE_BITS*i +: VARIABLE_BITS];
            ev_unassign[i] = ~assigned[lit_var];
            ev_val[i]      = value[lit_var];
        end
    end

    // Evaluation priority: satisfied, then unit, then conflict; anything else just moves on.
    assign any_unassigned = |(ev_unassign & ev_mask);
    assign eval_unit      = !ev_partial_sat && ev_is_unit;
    assign eval_conflict  = !ev_partial_sat && !ev_is_unit && !any_unassigned;
    assign do_advance     = ((state_q == S_EVAL) && !eval_unit && !eval_conflict) ||
                            ((state_q == S_EMIT) && imp_valid_q && imp_ready);
    assign idx_inc        = {1'b0, idx_q} + 1'b1;
    assign last_clause    = (idx_inc == {1'b0, num_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            num_q             <= '0;
            idx_q             <= '0;
            clause_q          <= '0;
            rd_en_q           <= 1'b0;
            rd_addr_q         <= '0;
            imp_valid_q       <= 1'b0;
            imp_var_q         <= '0;
            imp_val_q         <= 1'b0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            conflict_q        <= 1'b0;
            conflict_clause_q <= '0;
            imp_count_q       <= '0;
        end else begin
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_q             <= num_clauses;
                        idx_q             <= '0;
                        busy_q            <= 1'b1;
                        conflict_q        <= 1'b0;
                        conflict_clause_q <= '0;
                        imp_count_q       <= '0;
                        if (num_clauses == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= '0;
                            state_q   <= S_FETCH;
                        end
                    end
                end
                S_FETCH: state_q <= S_WAIT;
                S_WAIT: begin
                    clause_q <= clause_rd_data;
                    state_q  <= S_EVAL;
                end
                S_EVAL: begin
                    if (eval_unit) begin
                        imp_var_q   <= ev_implied_var;
                        imp_val_q   <= ev_new_val;
                        imp_valid_q <= 1'b1;
                        state_q     <= S_EMIT;
                    end else if (eval_conflict) begin
                        conflict_q        <= 1'b1;
                        conflict_clause_q <= idx_q;
                        state_q           <= S_DONE;
                    end
                end
                S_EMIT: begin
                    if (imp_ready) begin
                        imp_valid_q <= 1'b0;
                        imp_count_q <= imp_count_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            // Shared by the EVAL and EMIT exits; overrides the state hold above.
            if (do_advance) begin
                if (last_clause) begin
                    state_q <= S_DONE;
                end else begin
                    idx_q     <= idx_inc[CLAUSE_ADDR_BITS-1:0];
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= idx_inc[CLAUSE_ADDR_BITS-1:0];
                    state_q   <= S_FETCH;
                end
            end
        end
    end

    assign clause_rd_en    = rd_en_q;
    assign clause_rd_addr  = rd_addr_q;
    assign imp_valid       = imp_valid_q;
    assign imp_var         = imp_var_q;
    assign imp_val         = imp_val_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign conflict        = conflict_q;
    assign conflict_clause = conflict_clause_q;
    assign imp_count       = imp_count_q;

endmodule
